// File: rtl/bcd_div_checker_seq_if.sv
// bcd_div_checker_seq_if: start/operand request and result bundle for the sequential BCD divisibility checker
interface bcd_div_checker_seq_if #(parameter int NUM_DIGITS = 4, parameter int DIVISOR = 11);
  localparam int REM_W = $clog2(DIVISOR);
  logic start;
  logic [4*NUM_DIGITS-1:0] inp;
  logic busy;
  logic done;
  logic divisible;
  logic [REM_W-1:0] remainder;
  logic bcd_err;
  modport master (output start, inp, input busy, done, divisible, remainder, bcd_err);
  modport slave (input start, inp, output busy, done, divisible, remainder, bcd_err);
endinterface

// File: rtl/bcd_div_checker_seq.sv
// bcd_div_checker_seq: walks a packed-BCD operand MSD-first, one digit per clock, reporting its residue mod DIVISOR
module bcd_div_checker_seq #(
  parameter int NUM_DIGITS = 4,
  parameter int DIVISOR = 11
) (
  input logic clk,
  input logic rst,
  bcd_div_checker_seq_if.slave bus
);
  localparam int REM_W = $clog2(DIVISOR);
  localparam int W = REM_W + 4;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [IW-1:0] idx;
  logic [REM_W-1:0] rem, rem_nxt, remainder;
  logic [3:0] d;
  logic [W-1:0] acc;
  logic accept, divisible, bcd_err;
  assign d = 4'(shadow >> {idx, 2'b00});
  // W bits hold 10*(DIVISOR-1)+9 without overflow
  assign acc = W'(rem) * W'(10) + W'(d);
  assign rem_nxt = REM_W'(acc % W'(DIVISOR));
  assign accept = bus.start && (state == IDLE || state == DONE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shadow <= '0;
      idx <= '0;
      rem <= '0;
      remainder <= '0;
      divisible <= 1'b0;
      bcd_err <= 1'b0;
    end else if (accept) begin
      state <= RUN;
      shadow <= bus.inp;
      idx <= IW'(NUM_DIGITS - 1);
      rem <= '0;
      remainder <= '0;
      divisible <= 1'b0;
      bcd_err <= 1'b0;
    end else if (state == RUN) begin
      if (d > 4'd9) begin
        state <= DONE;
        bcd_err <= 1'b1;
      end else begin
        rem <= rem_nxt;
        idx <= idx - 1'b1;
        if (idx == '0) begin
          state <= DONE;
          remainder <= rem_nxt;
          divisible <= rem_nxt == '0;
        end
      end
    end else begin
      state <= IDLE;
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.divisible = divisible;
  assign bus.remainder = remainder;
  assign bus.bcd_err = bcd_err;
endmodule
